// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage core: ALU operand forwarding,
// load-use interlock, multi-cycle execute sequencing, branch flush and finish halt.
module hazard_ctrl #(
  parameter int unsigned MULTI_LAT = 4,
  parameter int unsigned REG_SIZE  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_SIZE-1:0] rs1D,
  input  logic [REG_SIZE-1:0] rs2D,
  input  logic                useRs1D,
  input  logic                useRs2D,
  input  logic [REG_SIZE-1:0] rs1E,
  input  logic [REG_SIZE-1:0] rs2E,
  input  logic [REG_SIZE-1:0] writeRegE,
  input  logic                regWriteE,
  input  logic                mem2regE,
  input  logic                validE,
  input  logic                multiE,
  input  logic [REG_SIZE-1:0] writeRegM,
  input  logic                regWriteM,
  input  logic                validM,
  input  logic [REG_SIZE-1:0] writeRegW,
  input  logic                regWriteW,
  input  logic                branchM,
  input  logic                zeroM,
  input  logic                finishM,
  output logic                stallF,
  output logic                stallD,
  output logic                stallE,
  output logic                flushD,
  output logic                flushE,
  output logic [1:0]          forwardAE,
  output logic [1:0]          forwardBE,
  output logic                multiDoneE,
  output logic                halted
);

  localparam int unsigned CW = $clog2(MULTI_LAT);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MULTI = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          taken_m, finish_m, lu, multi_e;

  function automatic logic [1:0] fwd_sel(
    input logic                valid_m,
    input logic                rw_m,
    input logic [REG_SIZE-1:0] wr_m,
    input logic                rw_w,
    input logic [REG_SIZE-1:0] wr_w,
    input logic [REG_SIZE-1:0] rs
  );
    if (valid_m && rw_m && (wr_m != '0) && (wr_m == rs)) return 2'b01;
    if (rw_w && (wr_w != '0) && (wr_w == rs))            return 2'b10;
    return 2'b00;
  endfunction

  assign taken_m  = validM & branchM & zeroM;
  assign finish_m = validM & finishM;
  assign multi_e  = validE & multiE;
  assign lu       = validE & mem2regE & regWriteE & (writeRegE != '0) &
                    ((useRs1D & (writeRegE == rs1D)) | (useRs2D & (writeRegE == rs2D)));

  // Controls are decoded combinationally from the current state so that branch
  // flush and finish act in the very cycle they are seen in M.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    stallF     = 1'b0;
    stallD     = 1'b0;
    stallE     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    multiDoneE = 1'b0;
    halted     = 1'b0;
    forwardAE  = fwd_sel(validM, regWriteM, writeRegM, regWriteW, writeRegW, rs1E);
    forwardBE  = fwd_sel(validM, regWriteM, writeRegM, regWriteW, writeRegW, rs2E);
    unique case (state)
      RUN: begin
        if (finish_m) begin
          {stallF, stallD, stallE} = 3'b111;
          state_nxt = HALT;
        end else if (taken_m) begin
          {flushD, flushE} = 2'b11;
        end else if (multi_e) begin
          {stallF, stallD, stallE} = 3'b111;
          cnt_nxt   = CW'(MULTI_LAT - 2);
          state_nxt = MULTI;
        end else if (lu) begin
          {stallF, stallD, flushE} = 3'b111;
        end
      end
      MULTI: begin
        if (taken_m) begin
          {flushD, flushE} = 2'b11;
          state_nxt = RUN;
        end else if (finish_m) begin
          {stallF, stallD, stallE} = 3'b111;
          state_nxt = HALT;
        end else if (cnt != '0) begin
          {stallF, stallD, stallE} = 3'b111;
          cnt_nxt = cnt - CW'(1);
        end else begin
          multiDoneE = 1'b1;
          state_nxt  = RUN;
          if (lu) {stallF, stallD, flushE} = 3'b111;
        end
      end
      HALT: begin
        halted = 1'b1;
        {stallF, stallD, stallE} = 3'b111;
      end
      default: state_nxt = RUN;
    endcase
    if (reset) begin
      {stallF, stallD, stallE, flushD, flushE, multiDoneE, halted} = '0;
      forwardAE = '0;
      forwardBE = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, hand-written multi-cycle sequences, and
// randomized cycles checked against a cycle-age reference model for MULTI_LAT 4 and 2.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1D, rs2D;
    logic       useRs1D, useRs2D;
    logic [4:0] rs1E, rs2E, writeRegE;
    logic       regWriteE, mem2regE, validE, multiE;
    logic [4:0] writeRegM;
    logic       regWriteM, validM;
    logic [4:0] writeRegW;
    logic       regWriteW, branchM, zeroM, finishM;
  } in_t;

  typedef struct packed {
    logic       sF, sD, sE, fD, fE;
    logic [1:0] fA, fB;
    logic       md, h;
  } out_t;

  typedef struct {
    bit mult;
    int age;
    bit halt;
  } mst_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  e;
  } vec_t;

  in_t  in;
  logic reset;
  out_t o4, o2;
  int   checks = 0;
  int   errors = 0;
  mst_t m4 = '{0, 0, 0};
  mst_t m2 = '{0, 0, 0};

  hazard_ctrl #(.MULTI_LAT(4), .REG_SIZE(5)) dut4 (
    .clk(clk), .reset(reset),
    .rs1D(in.rs1D), .rs2D(in.rs2D), .useRs1D(in.useRs1D), .useRs2D(in.useRs2D),
    .rs1E(in.rs1E), .rs2E(in.rs2E), .writeRegE(in.writeRegE), .regWriteE(in.regWriteE),
    .mem2regE(in.mem2regE), .validE(in.validE), .multiE(in.multiE),
    .writeRegM(in.writeRegM), .regWriteM(in.regWriteM), .validM(in.validM),
    .writeRegW(in.writeRegW), .regWriteW(in.regWriteW),
    .branchM(in.branchM), .zeroM(in.zeroM), .finishM(in.finishM),
    .stallF(o4.sF), .stallD(o4.sD), .stallE(o4.sE), .flushD(o4.fD), .flushE(o4.fE),
    .forwardAE(o4.fA), .forwardBE(o4.fB), .multiDoneE(o4.md), .halted(o4.h)
  );

  hazard_ctrl #(.MULTI_LAT(2), .REG_SIZE(5)) dut2 (
    .clk(clk), .reset(reset),
    .rs1D(in.rs1D), .rs2D(in.rs2D), .useRs1D(in.useRs1D), .useRs2D(in.useRs2D),
    .rs1E(in.rs1E), .rs2E(in.rs2E), .writeRegE(in.writeRegE), .regWriteE(in.regWriteE),
    .mem2regE(in.mem2regE), .validE(in.validE), .multiE(in.multiE),
    .writeRegM(in.writeRegM), .regWriteM(in.regWriteM), .validM(in.validM),
    .writeRegW(in.writeRegW), .regWriteW(in.regWriteW),
    .branchM(in.branchM), .zeroM(in.zeroM), .finishM(in.finishM),
    .stallF(o2.sF), .stallD(o2.sD), .stallE(o2.sE), .flushD(o2.fD), .flushE(o2.fE),
    .forwardAE(o2.fA), .forwardBE(o2.fB), .multiDoneE(o2.md), .halted(o2.h)
  );

  function automatic out_t mk(bit sF, bit sD, bit sE, bit fD, bit fE,
                              logic [1:0] fa, logic [1:0] fb, bit md, bit h);
    out_t o;
    o.sF = sF; o.sD = sD; o.sE = sE; o.fD = fD; o.fE = fE;
    o.fA = fa; o.fB = fb; o.md = md; o.h = h;
    return o;
  endfunction

  task automatic chk(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (sF sD sE fD fE fA fB md h)", name, act, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(in_t i, logic [4:0] rs);
    if (i.validM && i.regWriteM && i.writeRegM != 0 && i.writeRegM == rs) return 2'b01;
    if (i.regWriteW && i.writeRegW != 0 && i.writeRegW == rs) return 2'b10;
    return 2'b00;
  endfunction

  // Reference: a multi-cycle op is tracked by its age in E (0 = first cycle);
  // it stalls while age < L-1 and completes at age L-1.
  task automatic model(input in_t i, input bit rst, input int L, input mst_t s,
                       output out_t o, output mst_t n);
    bit taken, fin, lu;
    o = '0;
    n = s;
    taken = i.validM && i.branchM && i.zeroM;
    fin   = i.validM && i.finishM;
    lu    = i.validE && i.mem2regE && i.regWriteE && i.writeRegE != 0 &&
            ((i.useRs1D && i.writeRegE == i.rs1D) || (i.useRs2D && i.writeRegE == i.rs2D));
    if (rst) begin
      n = '{0, 0, 0};
      return;
    end
    o.fA = fwd_ref(i, i.rs1E);
    o.fB = fwd_ref(i, i.rs2E);
    if (s.halt) begin
      o.sF = 1; o.sD = 1; o.sE = 1; o.h = 1;
    end else if (!s.mult) begin
      if (fin) begin
        o.sF = 1; o.sD = 1; o.sE = 1; n.halt = 1;
      end else if (taken) begin
        o.fD = 1; o.fE = 1;
      end else if (i.validE && i.multiE) begin
        o.sF = 1; o.sD = 1; o.sE = 1; n.mult = 1; n.age = 1;
      end else if (lu) begin
        o.sF = 1; o.sD = 1; o.fE = 1;
      end
    end else begin
      if (taken) begin
        o.fD = 1; o.fE = 1; n.mult = 0;
      end else if (fin) begin
        o.sF = 1; o.sD = 1; o.sE = 1; n.mult = 0; n.halt = 1;
      end else if (s.age < L - 1) begin
        o.sF = 1; o.sD = 1; o.sE = 1; n.age = s.age + 1;
      end else begin
        o.md = 1; n.mult = 0;
        if (lu) begin
          o.sF = 1; o.sD = 1; o.fE = 1;
        end
      end
    end
  endtask

  task automatic cyc(input string name, input in_t i, input bit rst,
                     input bit has_exp, input out_t e);
    out_t x4, x2;
    mst_t n4, n2;
    @(negedge clk);
    in    = i;
    reset = rst;
    #2;
    model(i, rst, 4, m4, x4, n4);
    model(i, rst, 2, m2, x2, n2);
    chk({name, " L4-model"}, o4, x4);
    chk({name, " L2-model"}, o2, x2);
    if (has_exp) chk(name, o4, e);
    @(posedge clk);
    m4 = n4;
    m2 = n2;
  endtask

  function automatic in_t lu_in();
    in_t v = '0;
    v.validE = 1; v.mem2regE = 1; v.regWriteE = 1; v.writeRegE = 5'd3;
    v.useRs2D = 1; v.rs2D = 5'd3;
    return v;
  endfunction

  vec_t tbl[$];
  in_t  v, mv, lv, tk, fv;
  out_t z, st3, luo;

  initial begin
    z   = '0;
    st3 = mk(1, 1, 1, 0, 0, 0, 0, 0, 0);
    luo = mk(1, 1, 0, 0, 1, 0, 0, 0, 0);
    in  = '0;
    reset = 1'b1;

    // ---- vector table (state RUN throughout) ----
    v = '0; v.rs1E = 5; v.validM = 1; v.regWriteM = 1; v.writeRegM = 5;
    v.regWriteW = 1; v.writeRegW = 5;
    tbl.push_back('{"fwd_m_prio", v, mk(0,0,0,0,0,2'b01,0,0,0)});
    v.regWriteM = 0;
    tbl.push_back('{"fwd_w", v, mk(0,0,0,0,0,2'b10,0,0,0)});
    v.regWriteM = 1; v.writeRegM = 0;
    tbl.push_back('{"fwd_m_x0_w", v, mk(0,0,0,0,0,2'b10,0,0,0)});
    v = '0; v.rs1E = 0; v.validM = 1; v.regWriteM = 1; v.regWriteW = 1;
    tbl.push_back('{"fwd_x0", v, z});
    v = '0; v.rs1E = 5; v.regWriteM = 1; v.writeRegM = 5;
    tbl.push_back('{"fwd_m_invalid", v, z});
    v = '0; v.rs1E = 6; v.rs2E = 7; v.validM = 1; v.regWriteM = 1; v.writeRegM = 7;
    v.regWriteW = 1; v.writeRegW = 7;
    tbl.push_back('{"fwd_b_m", v, mk(0,0,0,0,0,0,2'b01,0,0)});
    v = '0; v.rs1E = 9; v.rs2E = 9; v.regWriteW = 1; v.writeRegW = 9;
    tbl.push_back('{"fwd_ab_w", v, mk(0,0,0,0,0,2'b10,2'b10,0,0)});
    v = lu_in();
    tbl.push_back('{"lu_rs2", v, luo});
    v.useRs2D = 0;
    tbl.push_back('{"lu_unused", v, z});
    v.useRs1D = 1; v.rs1D = 3;
    tbl.push_back('{"lu_rs1", v, luo});
    v = lu_in(); v.writeRegE = 0; v.rs2D = 0;
    tbl.push_back('{"lu_x0", v, z});
    v = lu_in(); v.mem2regE = 0;
    tbl.push_back('{"lu_not_load", v, z});
    v = lu_in(); v.validE = 0;
    tbl.push_back('{"lu_invalid", v, z});
    tk = '0; tk.validM = 1; tk.branchM = 1; tk.zeroM = 1;
    tbl.push_back('{"taken", tk, mk(0,0,0,1,1,0,0,0,0)});
    v = tk; v.zeroM = 0;
    tbl.push_back('{"not_taken", v, z});
    v = lu_in(); v.validM = 1; v.branchM = 1; v.zeroM = 1;
    tbl.push_back('{"taken_over_lu", v, mk(0,0,0,1,1,0,0,0,0)});

    v = lu_in(); v.rs1E = 5; v.validM = 1; v.regWriteM = 1; v.writeRegM = 5;
    cyc("reset_out0", v, 1, 1, z);
    cyc("reset_out0_b", v, 1, 1, z);
    foreach (tbl[k]) cyc(tbl[k].name, tbl[k].i, 0, 1, tbl[k].e);

    // ---- load-use then forward from M ----
    cyc("rst", '0, 1, 1, z);
    cyc("lu_seq_stall", lu_in(), 0, 1, luo);
    v = '0; v.validM = 1; v.regWriteM = 1; v.writeRegM = 3; v.rs2E = 3;
    cyc("lu_seq_fwd", v, 0, 1, mk(0,0,0,0,0,0,2'b01,0,0));

    // ---- multi-cycle op, MULTI_LAT=4 ----
    mv = '0; mv.validE = 1; mv.multiE = 1; mv.regWriteE = 1; mv.writeRegE = 4;
    cyc("rst", '0, 1, 1, z);
    for (int k = 0; k < 3; k++) cyc("multi_stall", mv, 0, 1, st3);
    cyc("multi_done", mv, 0, 1, mk(0,0,0,0,0,0,0,1,0));
    cyc("multi_back_run", lu_in(), 0, 1, luo);

    // ---- abort by older taken branch ----
    cyc("rst", '0, 1, 1, z);
    cyc("abort_start", mv, 0, 1, st3);
    v = mv; v.validM = 1; v.branchM = 1; v.zeroM = 1;
    cyc("abort_flush", v, 0, 1, mk(0,0,0,1,1,0,0,0,0));
    cyc("abort_idle", '0, 0, 1, z);
    cyc("abort_run", lu_in(), 0, 1, luo);

    // ---- load-use coinciding with multiDoneE ----
    cyc("rst", '0, 1, 1, z);
    lv = lu_in(); lv.multiE = 1;
    for (int k = 0; k < 3; k++) cyc("multi_lu_suppressed", lv, 0, 1, st3);
    cyc("multi_done_lu", lv, 0, 1, mk(1,1,0,0,1,0,0,1,0));

    // ---- finish, sticky halt, reset ----
    cyc("rst", '0, 1, 1, z);
    fv = '0; fv.validM = 1; fv.finishM = 1;
    cyc("finish", fv, 0, 1, st3);
    for (int k = 0; k < 3; k++) cyc("halted", '0, 0, 1, mk(1,1,1,0,0,0,0,0,1));
    cyc("halted_ignores_branch", tk, 0, 1, mk(1,1,1,0,0,0,0,0,1));
    cyc("halt_reset", fv, 1, 1, z);
    cyc("after_halt_reset", '0, 0, 1, z);

    // ---- randomized against the reference model ----
    for (int n = 0; n < 3000; n++) begin
      v = '0;
      v.rs1D = 5'($urandom_range(0, 3));  v.rs2D = 5'($urandom_range(0, 3));
      v.rs1E = 5'($urandom_range(0, 3));  v.rs2E = 5'($urandom_range(0, 3));
      v.writeRegE = 5'($urandom_range(0, 3));
      v.writeRegM = 5'($urandom_range(0, 3));
      v.writeRegW = 5'($urandom_range(0, 3));
      v.useRs1D   = 1'($urandom_range(0, 1));
      v.useRs2D   = 1'($urandom_range(0, 1));
      v.regWriteE = 1'($urandom_range(0, 1));
      v.mem2regE  = 1'($urandom_range(0, 1));
      v.validE    = ($urandom_range(0, 3) != 0);
      v.multiE    = ($urandom_range(0, 5) == 0);
      v.regWriteM = 1'($urandom_range(0, 1));
      v.validM    = ($urandom_range(0, 3) != 0);
      v.regWriteW = 1'($urandom_range(0, 1));
      v.branchM   = ($urandom_range(0, 3) == 0);
      v.zeroM     = 1'($urandom_range(0, 1));
      v.finishM   = ($urandom_range(0, 63) == 0);
      cyc("random", v, ($urandom_range(0, 63) == 0), 0, z);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
